// File: rtl/load_align_unit.sv
// load_align_unit: word-aligned data-memory read with byte/half extraction and sign/zero extension; LOAD_MISALIGN_CHK_EN enables misaligned-load trapping
`ifndef REG_LEN
`define REG_LEN 32
`endif
module load_align_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [2:0]          ld_type,
    input  logic [`REG_LEN-1:0] ld_addr,
    output logic                mem_req,
    output logic [`REG_LEN-1:0] mem_addr,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [`REG_LEN-1:0] mem_rdata,
    output logic                rd_valid,
    output logic [`REG_LEN-1:0] rd_data,
    output logic                rd_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [2:0] typ;
    logic [1:0] ofs;
    logic [7:0] cnt;
    logic       misalign;
    logic       timeout;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    logic [`REG_LEN-1:0] ext;
`ifdef LOAD_MISALIGN_CHK_EN
    logic is_half, is_byte;
    assign is_half  = ld_type == 3'b001 || ld_type == 3'b100;
    assign is_byte  = ld_type == 3'b000 || ld_type == 3'b011;
    assign misalign = is_half ? ld_addr[0] : (!is_byte && ld_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign timeout  = cnt == 8'(TIMEOUT - 1);
    assign ld_ready = state == IDLE;
    assign mem_req  = state == REQ;
    assign rd_valid = state == RESP;
    assign byte_sel = mem_rdata[{ofs, 3'b000} +: 8];
    assign half_sel = ofs[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    // Extract the addressed lane of the returned word and extend it by load type
    always_comb begin
        ext = mem_rdata;
        case (typ)
            3'b000:  ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext = {{16{half_sel[15]}}, half_sel};
            3'b011:  ext = {24'b0, byte_sel};
            3'b100:  ext = {16'b0, half_sel};
            default: ext = mem_rdata;
        endcase
    end
    // Next-state logic: misaligned loads skip memory, WAIT ends on rvalid or timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ld_valid ? (misalign ? RESP : REQ) : IDLE;
            REQ:     state_nxt = mem_gnt ? WAIT : REQ;
            WAIT:    state_nxt = (mem_rvalid || timeout) ? RESP : WAIT;
            default: state_nxt = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // Request latching, wait counter and result capture; results hold until next response
    always_ff @(posedge clk) begin
        if (rst) begin
            typ      <= 3'b0;
            ofs      <= 2'b0;
            cnt      <= 8'b0;
            mem_addr <= '0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else if (state == IDLE && ld_valid) begin
            typ      <= ld_type;
            ofs      <= ld_addr[1:0];
            cnt      <= 8'b0;
            mem_addr <= {ld_addr[`REG_LEN-1:2], 2'b00};
            if (misalign) begin
                rd_data <= '0;
                rd_err  <= 1'b1;
            end
        end else if (state == WAIT) begin
            if (mem_rvalid) begin
                rd_data <= ext;
                rd_err  <= 1'b0;
            end else if (timeout) begin
                rd_data <= '0;
                rd_err  <= 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: vector table plus corner sequences, results checked through a scoreboard queue
`ifndef REG_LEN
`define REG_LEN 32
`endif
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [2:0]  ld_type = 3'b0;
    logic [31:0] ld_addr = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [2:0]  t;
        logic [31:0] a;
        logic [31:0] w;
        int          gd;
        int          rd;
        logic [31:0] ed;
        logic        ee;
    } vec_t;
    vec_t vecs[$];

    load_align_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_type(ld_type), .ld_addr(ld_addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every rd_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rd_valid: got data %h err %b, expected no response", rd_data, rd_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rd_data", rd_data, e.d);
                chk("rd_err", {31'b0, rd_err}, {31'b0, e.e});
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int n = 0;
        while (!ld_ready && n < 50) begin
            step();
            n++;
        end
        chk("ld_ready_wait", {31'b0, ld_ready}, 32'd1);
    endtask

    task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                           input int gd, input int rd, input logic [31:0] ed, input logic ee);
        wait_ready();
        exp_q.push_back({ed, ee});
        ld_valid = 1'b1;
        ld_type  = t;
        ld_addr  = a;
        step();
        ld_valid = 1'b0;
        ld_addr  = 32'hFFFF_FFFF;
        for (int i = 0; i < gd; i++) begin
            chk("mem_req_hold", {31'b0, mem_req}, 32'd1);
            chk("mem_addr_hold", mem_addr, {a[31:2], 2'b00});
            step();
        end
        chk("mem_req", {31'b0, mem_req}, 32'd1);
        chk("mem_addr", mem_addr, {a[31:2], 2'b00});
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("mem_req_drop", {31'b0, mem_req}, 32'd0);
        repeat (rd) step();
        chk("rd_valid_early", {31'b0, rd_valid}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = w;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h5A5A_5A5A;
        chk("rd_valid_pulse", {31'b0, rd_valid}, 32'd1);
        chk("ld_ready_busy", {31'b0, ld_ready}, 32'd0);
        step();
        chk("rd_valid_one_cycle", {31'b0, rd_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs.push_back('{3'b000, 32'h103, 32'h80AA_BBCC, 0, 0, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{3'b100, 32'h202, 32'h9234_5678, 0, 0, 32'h0000_9234, 1'b0});
        vecs.push_back('{3'b001, 32'h202, 32'h9234_5678, 1, 0, 32'hFFFF_9234, 1'b0});
        vecs.push_back('{3'b010, 32'h040, 32'hDEAD_BEEF, 3, 1, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{3'b011, 32'h101, 32'h0000_F100, 0, 2, 32'h0000_00F1, 1'b0});
        vecs.push_back('{3'b001, 32'h200, 32'h1234_8001, 0, 0, 32'hFFFF_8001, 1'b0});
        vecs.push_back('{3'b100, 32'h200, 32'h1234_8001, 2, 0, 32'h0000_8001, 1'b0});
        vecs.push_back('{3'b000, 32'h100, 32'h0000_007F, 0, 0, 32'h0000_007F, 1'b0});
        vecs.push_back('{3'b011, 32'h102, 32'h00AB_0000, 0, 0, 32'h0000_00AB, 1'b0});
        vecs.push_back('{3'b000, 32'h102, 32'h00AB_0000, 0, 3, 32'hFFFF_FFAB, 1'b0});
        vecs.push_back('{3'b111, 32'h010, 32'h1122_3344, 0, 0, 32'h1122_3344, 1'b0});
`ifndef LOAD_MISALIGN_CHK_EN
        vecs.push_back('{3'b010, 32'h006, 32'hCAFE_F00D, 0, 0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{3'b001, 32'h203, 32'h8765_4321, 0, 0, 32'hFFFF_8765, 1'b0});
`endif

        repeat (3) step();
        rst = 1'b0;
        chk("reset_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_rd_err", {31'b0, rd_err}, 32'd0);

        // rvalid outside WAIT is ignored
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_1111;
        step();
        mem_rvalid = 1'b0;
        chk("idle_rvalid_ignored", {31'b0, rd_valid}, 32'd0);

        foreach (vecs[i]) do_load(vecs[i].t, vecs[i].a, vecs[i].w, vecs[i].gd, vecs[i].rd, vecs[i].ed, vecs[i].ee);

        repeat (3) step();
        chk("rd_data_hold", rd_data, vecs[vecs.size()-1].ed);

        // Timeout: 16 WAIT cycles without rvalid produce an error response
        wait_ready();
        exp_q.push_back({32'd0, 1'b1});
        ld_valid = 1'b1;
        ld_type  = 3'b010;
        ld_addr  = 32'h80;
        step();
        ld_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int k = 1; k < 16; k++) begin
            step();
            chk("timeout_not_yet", {31'b0, rd_valid}, 32'd0);
        end
        step();
        chk("timeout_rd_valid", {31'b0, rd_valid}, 32'd1);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h2222_2222;
        step();
        chk("late_rvalid_1", {31'b0, rd_valid}, 32'd0);
        step();
        mem_rvalid = 1'b0;
        chk("late_rvalid_2", {31'b0, rd_valid}, 32'd0);

        // rvalid on the final WAIT cycle beats the timeout
        wait_ready();
        exp_q.push_back({32'h3333_4444, 1'b0});
        ld_valid = 1'b1;
        ld_type  = 3'b010;
        ld_addr  = 32'h84;
        step();
        ld_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        repeat (15) step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h3333_4444;
        step();
        mem_rvalid = 1'b0;
        chk("rvalid_wins_pulse", {31'b0, rd_valid}, 32'd1);
        step();

        // Reset in WAIT aborts the load
        wait_ready();
        ld_valid = 1'b1;
        ld_type  = 3'b010;
        ld_addr  = 32'h300;
        step();
        ld_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_ld_ready", {31'b0, ld_ready}, 32'd1);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rd_err", {31'b0, rd_err}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h4444_4444;
        step();
        mem_rvalid = 1'b0;
        chk("rst_late_rvalid", {31'b0, rd_valid}, 32'd0);
        do_load(3'b011, 32'h1, 32'h0000_F100, 0, 0, 32'h0000_00F1, 1'b0);

`ifdef LOAD_MISALIGN_CHK_EN
        // Misaligned loads answer with an error without touching memory
        for (int m = 0; m < 2; m++) begin
            wait_ready();
            exp_q.push_back({32'd0, 1'b1});
            ld_valid = 1'b1;
            ld_type  = (m == 0) ? 3'b010 : 3'b001;
            ld_addr  = (m == 0) ? 32'h6 : 32'h201;
            step();
            ld_valid = 1'b0;
            chk("misalign_no_req", {31'b0, mem_req}, 32'd0);
            chk("misalign_rd_valid", {31'b0, rd_valid}, 32'd1);
            step();
            chk("misalign_done", {31'b0, rd_valid}, 32'd0);
            chk("misalign_no_req_after", {31'b0, mem_req}, 32'd0);
        end
`endif

        repeat (2) step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
